score_keeper: RTL and testbench
===============================

# score_keeper

Game score source for the single-digit points display: it counts hit events from the game logic, applies a cooldown so one collision scores once, and saturates at the display's maximum of 12 points. It sits between the collision/game-control logic and `points_handler`, driving that block's 4-bit `points` input and flagging game over. All logic runs in the `pclk` domain.

## Interface
- `MAX_POINTS`, 12, score at which the game ends; must be ≤ 15.
- `COOLDOWN_CYCLES`, 65_000_000, cycles after a scored hit during which hits are ignored; must be ≥ 1.
- `pclk`  input  1  clock.
- `rst`  input  1  reset, synchronous, active-high.
- `start`  input  1  single-cycle pulse; starts or restarts a game.
- `hit`  input  1  collision level from game logic, already in the `pclk` domain; may stay high for many cycles.
- `points`  output  4  current score, registered; connects to `points_handler.points`.
- `points_upd`  output  1  one-cycle pulse, high in the same cycle that `points` first shows a new value.
- `game_over`  output  1  high while in DONE.
- `playing`  output  1  high in PLAY or COOL.

## Operation
- Edge detect: `hit_q` is `hit` registered every cycle in all states, reset 0. `hit_rise = hit & ~hit_q`.
- States are IDLE, PLAY, COOL and DONE. Reset state is IDLE.
- IDLE:
  - `points` = 0.
  - `start` → PLAY with `points` = 0.
  - Hits are ignored.
- PLAY:
  - On `hit_rise`, `points` ← `points`+1 and `points_upd` pulses.
  - If the new value equals `MAX_POINTS`, go to DONE. Otherwise go to COOL and load the cooldown counter with `COOLDOWN_CYCLES`−1.
- COOL:
  - The counter decrements each cycle. When it reaches 0, go to PLAY on the next edge.
  - Rises are ignored. A `hit` still high when PLAY resumes does not score, because it is not a new rise.
- DONE:
  - `points` holds `MAX_POINTS` and `game_over` = 1.
  - `start` → PLAY with `points` = 0.
  - Hits are ignored.
- `start` in PLAY or COOL restarts: `points` = 0, state PLAY, cooldown counter cleared. `points_upd` pulses only if `points` was nonzero.
- `start` and `hit_rise` in the same cycle: `start` wins and the hit is discarded.
- `points` is never above `MAX_POINTS`; increment is 4-bit with no wrap.
- Cooldown counter width is `$clog2(COOLDOWN_CYCLES)`, minimum 1.

## Timing
- Reset values:
  - `points` = 0, `points_upd` = 0, `game_over` = 0, `playing` = 0.
  - `hit_q` = 0, cooldown counter = 0, state IDLE.
- Latency: with `hit` first sampled high at edge N in PLAY, `points` and `points_upd` change after edge N, which is 1 cycle.
- State outputs change on the edge that enters the state.
- Scoring gap: minimum spacing between two scored hits is `COOLDOWN_CYCLES`+1 cycles. This is one scoring cycle in PLAY, `COOLDOWN_CYCLES` cycles in COOL, then a new rise.
- `rst` mid-game, in any state, returns to IDLE with all outputs 0 on the next edge and takes priority over `start`.
- `hit` held high through reset release: `hit_q` is 0 after reset, so a rise is seen on the first cycle, but IDLE ignores it.

## Structure
- Shared game package holds:
  - the state enum, 2-bit, IDLE/PLAY/COOL/DONE;
  - `SCORE_W` = 4;
  - the `MAX_POINTS` default of 12, shared with `points_handler`'s supported range.
- Sub-module: `edge_detect_rise`, a 1-bit register plus AND, reused for other game pulses.
- The rest is one FSM with a next-state combinational block and one registered block.

## Test plan
Benches use `COOLDOWN_CYCLES` = 4 and `MAX_POINTS` = 12 unless noted.
- Reset then idle hits: `rst` for 2 cycles, then `hit` toggling with no `start` → `points` = 0, `playing` = 0, no `points_upd`.
- Single scored hit: `start`, then `hit` held high for 20 cycles → `points` goes 0→1 exactly once, 1 cycle after the first high sample; one `points_upd` pulse; state PLAY→COOL→PLAY with no second score.
- Cooldown window:
  - Two rises 3 cycles apart → only the first scores (`points` = 1).
  - Rises 6 cycles apart → `points` = 2.
- Saturation: 12 spaced rises → `points` = 12 and `game_over` = 1 after the 12th. A further 5 rises leave `points` = 12. Then `start` → `points` = 0, `playing` = 1, `game_over` = 0.
- Restart priority: at `points` = 5, `start` and a rise in the same cycle → `points` = 0 next cycle, state PLAY, the hit is not counted, one `points_upd` pulse.
- Reset mid-game: `rst` during COOL at `points` = 7 → next cycle `points` = 0, state IDLE, all outputs 0.

Source files
------------

// File: rtl/score_keeper_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : score_keeper_pkg                                              |
// | Purpose  : Shared game definitions: the game FSM state type, the width   |
// |            of the points bus and the default points ceiling, which also  |
// |            bounds what points_handler can display.                       |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package score_keeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_COOL = 2'd2,
    ST_DONE = 2'd3
  } game_state_t;

  localparam int SCORE_W            = 4;
  localparam int DEFAULT_MAX_POINTS = 12;

endpackage
`default_nettype wire

// File: rtl/edge_detect_rise.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : edge_detect_rise                                              |
// | Purpose  : Rising-edge detector for a signal already in the pclk domain. |
// |            One register holds the previous sample; rise is high for the  |
// |            cycle in which sig is high and was low on the previous edge.  |
// | Ports    : pclk  in  clock                                               |
// |            rst   in  synchronous active-high reset (clears history)      |
// |            sig   in  level to watch                                      |
// |            rise  out combinational rising-edge strobe                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module edge_detect_rise (
  input  logic pclk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge pclk) begin
    if (rst) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  // A level held high through reset release reads as a rise on the first
  // cycle after reset; consumers decide whether that matters.
  assign rise = sig & ~sig_q;

endmodule
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : score_keeper                                                  |
// | Purpose  : Counts hit events into the points display. Each scored hit    |
// |            starts a cooldown so one collision scores once; the score     |
// |            saturates at MAX_POINTS, which ends the game.                 |
// | Ports    : pclk        in  clock                                         |
// |            rst         in  synchronous active-high reset                 |
// |            start       in  one-cycle pulse, starts/restarts a game       |
// |            hit         in  collision level (pclk domain)                 |
// |            points      out registered score to points_handler            |
// |            points_upd  out one-cycle pulse when points changes           |
// |            game_over   out high while the game is finished               |
// |            playing     out high while the game is running or cooling     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int MAX_POINTS      = DEFAULT_MAX_POINTS,
  parameter int COOLDOWN_CYCLES = 65_000_000
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               start,
  input  logic               hit,
  output logic [SCORE_W-1:0] points,
  output logic               points_upd,
  output logic               game_over,
  output logic               playing
);

  localparam int CNT_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

  localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(MAX_POINTS);
  localparam logic [CNT_W-1:0]   COOL_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);

  game_state_t        state;
  game_state_t        state_nxt;
  logic [SCORE_W-1:0] points_nxt;
  logic [CNT_W-1:0]   cool_cnt;
  logic [CNT_W-1:0]   cool_cnt_nxt;
  logic               points_upd_nxt;
  logic               hit_rise;

  edge_detect_rise u_hit_edge (
    .pclk (pclk),
    .rst  (rst),
    .sig  (hit),
    .rise (hit_rise)
  );

  always_comb begin
    state_nxt    = state;
    points_nxt   = points;
    cool_cnt_nxt = cool_cnt;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt  = ST_PLAY;
          points_nxt = '0;
        end
      end

      ST_PLAY: begin
        // start outranks a simultaneous rise; that hit is simply dropped.
        if (start) begin
          points_nxt   = '0;
          cool_cnt_nxt = '0;
        end else if (hit_rise && (points < MAX_SCORE)) begin
          points_nxt = points + SCORE_W'(1);
          if (points_nxt == MAX_SCORE) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt    = ST_COOL;
            cool_cnt_nxt = COOL_LOAD;
          end
        end
      end

      ST_COOL: begin
        // The counter is loaded with COOLDOWN_CYCLES-1 and leaves on the
        // edge after it reads zero, so COOL lasts exactly COOLDOWN_CYCLES.
        if (start) begin
          state_nxt    = ST_PLAY;
          points_nxt   = '0;
          cool_cnt_nxt = '0;
        end else if (cool_cnt == '0) begin
          state_nxt = ST_PLAY;
        end else begin
          cool_cnt_nxt = cool_cnt - CNT_W'(1);
        end
      end

      ST_DONE: begin
        if (start) begin
          state_nxt  = ST_PLAY;
          points_nxt = '0;
        end
      end

      default: begin
        state_nxt    = ST_IDLE;
        points_nxt   = '0;
        cool_cnt_nxt = '0;
      end
    endcase

    // Pulse lines up with the first cycle the display sees the new value;
    // a restart from a zero score therefore produces no pulse.
    points_upd_nxt = (points_nxt != points);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state      <= ST_IDLE;
      points     <= '0;
      cool_cnt   <= '0;
      points_upd <= 1'b0;
    end else begin
      state      <= state_nxt;
      points     <= points_nxt;
      cool_cnt   <= cool_cnt_nxt;
      points_upd <= points_upd_nxt;
    end
  end

  assign game_over = (state == ST_DONE);
  assign playing   = (state == ST_PLAY) || (state == ST_COOL);

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_score_keeper                                               |
// | Purpose  : Self-checking bench for score_keeper. A cycle-level score     |
// |            model (score, active/over flags, cycle of last scored hit)    |
// |            predicts every output after every edge, plus directed checks  |
// |            for the headline scenarios.                                   |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_score_keeper;

  localparam int MAX_P = 12;
  localparam int COOL  = 4;

  logic       pclk = 1'b0;
  logic       rst  = 1'b1;
  logic       start = 1'b0;
  logic       hit  = 1'b0;
  logic [3:0] points;
  logic       points_upd;
  logic       game_over;
  logic       playing;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int score     = 0;
  bit active    = 1'b0;
  bit over      = 1'b0;
  bit prev_hit  = 1'b0;
  bit exp_upd   = 1'b0;
  int last_cyc  = -1000;
  int cyc       = 0;

  score_keeper #(
    .MAX_POINTS      (MAX_P),
    .COOLDOWN_CYCLES (COOL)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .start      (start),
    .hit        (hit),
    .points     (points),
    .points_upd (points_upd),
    .game_over  (game_over),
    .playing    (playing)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Applies inputs for one cycle, advances the model by the game rules and
  // compares all outputs just after the edge.
  task automatic step(input bit s, input bit h, input bit r);
    int  old;
    bit  rise;
    start = s;
    hit   = h;
    rst   = r;
    @(posedge pclk);
    rise = h && !prev_hit;
    if (r) begin
      score = 0; active = 0; over = 0; prev_hit = 0; exp_upd = 0; last_cyc = -1000;
    end else begin
      old      = score;
      prev_hit = h;
      if (s) begin
        score = 0; active = 1; over = 0; last_cyc = -1000;
      end else if (active && !over && rise && (cyc - last_cyc >= COOL + 1)) begin
        score++;
        last_cyc = cyc;
        if (score == MAX_P) over = 1;
      end
      exp_upd = (score != old);
    end
    cyc++;
    #1;
    chk("points", int'(points), score);
    chk("points_upd", int'(points_upd), int'(exp_upd));
    chk("game_over", int'(game_over), int'(over));
    chk("playing", int'(playing), int'(active && !over));
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic rises(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      step(0, 1, 0);
      for (int j = 1; j < gap; j++) step(0, 0, 0);
    end
  endtask

  initial begin
    // Reset, then hits with no start
    step(0, 1, 1);
    step(0, 1, 1);
    for (int i = 0; i < 8; i++) step(0, i[0], 0);
    chk("idle_points", int'(points), 0);
    chk("idle_playing", int'(playing), 0);

    // Single scored hit with hit held high
    step(1, 0, 0);
    step(0, 1, 0);
    chk("first_hit_points", int'(points), 1);
    chk("first_hit_upd", int'(points_upd), 1);
    for (int i = 0; i < 19; i++) step(0, 1, 0);
    chk("held_hit_points", int'(points), 1);
    step(0, 0, 0);

    // Two rises 3 cycles apart: second falls inside cooldown
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    chk("cool_3apart", int'(points), 1);

    // Rises 6 cycles apart: both score
    step(1, 0, 0);
    rises(2, 6);
    chk("cool_6apart", int'(points), 2);

    // Saturation
    step(1, 0, 0);
    rises(12, 6);
    chk("sat_points", int'(points), 12);
    chk("sat_over", int'(game_over), 1);
    rises(5, 3);
    chk("sat_hold", int'(points), 12);
    step(1, 0, 0);
    chk("restart_done_points", int'(points), 0);
    chk("restart_done_playing", int'(playing), 1);
    chk("restart_done_over", int'(game_over), 0);

    // Restart priority over a simultaneous rise at points=5
    rises(5, 6);
    step(1, 1, 0);
    chk("prio_points", int'(points), 0);
    chk("prio_upd", int'(points_upd), 1);
    step(0, 1, 0);
    chk("prio_nohit", int'(points), 0);
    step(0, 0, 0);

    // Reset in COOL at points=7
    step(1, 0, 0);
    rises(6, 6);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("pre_rst_points", int'(points), 7);
    step(1, 0, 1);
    chk("rst_points", int'(points), 0);
    chk("rst_playing", int'(playing), 0);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 199) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
